b_cache_seq_ctrl: RTL

Sequencer that sits directly upstream of the B-cache write-data mapper and drives it: `B_cache_in_sel`, `seq_cnt_out`, B-cache write enable and write address, plus the transpose-buffer (TB) read port.
- A start/done handshake from the EKF top-level controller launches one B-cache fill.
- Fill modes: predict Jacobian (PRD), new-landmark Jacobian (NEW), update Jacobian (UPD), 2x2 inverse (INV), transpose copy.
- Write enable is delayed to line up with the mapper's one-cycle registered `B_cache_din`, so each write lands on valid data.

---
 rtl/b_cache_seq_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/b_cache_seq_ctrl.sv
// B-cache fill sequencer: drives the write-data mapper's mode/sequence index, the B-cache
// write port (delayed to match the mapper's registered data) and the transpose-buffer read port.
module b_cache_seq_ctrl #(
  parameter int unsigned SEQ_CNT_DW = 10,
  parameter int unsigned BCA_AW     = 10,
  parameter int unsigned TB_AW      = 10
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  op_start,
  input  logic [2:0]            op_mode,
  input  logic [BCA_AW-1:0]     base_addr,
  input  logic [SEQ_CNT_DW-1:0] transpose_len,
  output logic                  busy,
  output logic                  done,
  output logic                  op_err,
  output logic [3:0]            B_cache_in_sel,
  output logic [SEQ_CNT_DW-1:0] seq_cnt_out,
  output logic                  B_cache_wen,
  output logic [BCA_AW-1:0]     B_cache_waddr,
  output logic                  B_cache_TB_renb,
  output logic [TB_AW-1:0]      B_cache_TB_addrb
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] MODE_PRD = 3'd0;
  localparam logic [2:0] MODE_NEW = 3'd1;
  localparam logic [2:0] MODE_UPD = 3'd2;
  localparam logic [2:0] MODE_INV = 3'd3;
  localparam logic [2:0] MODE_TR  = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [BCA_AW-1:0]     base_q, base_d;
  logic [SEQ_CNT_DW-1:0] len_q, len_d;
  logic                  drain_q, drain_d;
  logic                  s1_v_q, s1_v_d;
  logic [BCA_AW-1:0]     s1_addr_q, s1_addr_d;

  logic                  busy_d, done_d, err_d, wen_d, renb_d;
  logic [3:0]            sel_d;
  logic [SEQ_CNT_DW-1:0] seq_d;
  logic [BCA_AW-1:0]     waddr_d;
  logic [TB_AW-1:0]      addrb_d;

  logic                  cur_wr_c;
  logic [BCA_AW-1:0]     cur_addr_c;
  logic                  is_tr_c;
  logic [SEQ_CNT_DW-1:0] start_len_c;

  function automatic logic [3:0] sel_code(input logic [2:0] m);
    case (m)
      MODE_PRD: sel_code = 4'b1101;
      MODE_NEW: sel_code = 4'b1110;
      MODE_UPD: sel_code = 4'b1111;
      MODE_INV: sel_code = 4'b1010;
      MODE_TR:  sel_code = 4'b1001;
      default:  sel_code = 4'b0000;
    endcase
  endfunction

  // Sequence length of the mode being launched
  always_comb begin
    case (op_mode)
      MODE_PRD: start_len_c = SEQ_CNT_DW'(5);
      MODE_NEW: start_len_c = SEQ_CNT_DW'(6);
      MODE_UPD: start_len_c = SEQ_CNT_DW'(7);
      MODE_INV: start_len_c = SEQ_CNT_DW'(9);
      default:  start_len_c = transpose_len;
    endcase
  end

  // INV steps 1..6 are internal accumulation; only 7..9 produce rows
  assign is_tr_c    = (mode_q == MODE_TR);
  assign cur_wr_c   = (state_q == S_RUN) &&
                      ((mode_q != MODE_INV) || (seq_cnt_out >= SEQ_CNT_DW'(7)));
  assign cur_addr_c = base_q + BCA_AW'(seq_cnt_out) -
                      ((mode_q == MODE_INV) ? BCA_AW'(7) : BCA_AW'(1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    len_d     = len_q;
    drain_d   = drain_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sel_d     = 4'b0000;
    seq_d     = '0;
    renb_d    = 1'b0;
    addrb_d   = '0;
    // Transpose needs one extra stage for the TB read latency
    s1_v_d    = cur_wr_c;
    s1_addr_d = cur_addr_c;
    wen_d     = is_tr_c ? s1_v_q : cur_wr_c;
    waddr_d   = is_tr_c ? s1_addr_q : cur_addr_c;
    if (!wen_d) waddr_d = B_cache_waddr;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (op_start && (op_mode <= MODE_TR)) begin
          mode_d = op_mode;
          base_d = base_addr;
          len_d  = start_len_c;
          if (start_len_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            sel_d   = sel_code(op_mode);
            seq_d   = SEQ_CNT_DW'(1);
            renb_d  = (op_mode == MODE_TR);
          end
        end else if (op_start) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        sel_d  = sel_code(mode_q);
        if (seq_cnt_out == len_q) begin
          state_d = S_DRAIN;
          drain_d = is_tr_c;
        end else begin
          seq_d   = seq_cnt_out + SEQ_CNT_DW'(1);
          renb_d  = is_tr_c;
          addrb_d = is_tr_c ? TB_AW'(seq_cnt_out) : '0;
        end
      end
      default: begin
        if (drain_q) begin
          drain_d = 1'b0;
          busy_d  = 1'b1;
          sel_d   = sel_code(mode_q);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q          <= S_IDLE;
      mode_q           <= '0;
      base_q           <= '0;
      len_q            <= '0;
      drain_q          <= 1'b0;
      s1_v_q           <= 1'b0;
      s1_addr_q        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      op_err           <= 1'b0;
      B_cache_in_sel   <= 4'b0000;
      seq_cnt_out      <= '0;
      B_cache_wen      <= 1'b0;
      B_cache_waddr    <= '0;
      B_cache_TB_renb  <= 1'b0;
      B_cache_TB_addrb <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      base_q           <= base_d;
      len_q            <= len_d;
      drain_q          <= drain_d;
      s1_v_q           <= s1_v_d;
      s1_addr_q        <= s1_addr_d;
      busy             <= busy_d;
      done             <= done_d;
      op_err           <= err_d;
      B_cache_in_sel   <= sel_d;
      seq_cnt_out      <= seq_d;
      B_cache_wen      <= wen_d;
      B_cache_waddr    <= waddr_d;
      B_cache_TB_renb  <= renb_d;
      B_cache_TB_addrb <= addrb_d;
    end
  end

endmodule
